ps2_host_tx: RTL

- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same PS2_CLK/PS2_DATA pair the keyboard decoder receives on.
- Runs the request-to-send sequence (clock inhibit, start bit, device-clocked shift-out, stop, ACK check) and reports success or failure.
- Sits beside the decoder. The top level ties both open-drain enables onto the inout pins: pin = 0 when oe=1, else 'z'.

---
 rtl/ps2_host_tx.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, start bit, device-clocked
// shift-out of data/parity/stop, ACK check, with one done/err pulse per command.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int FILTER_LEN     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLT_W   = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, SEND, ACK, WAIT_IDLE, DONE, ERR} state_t;

  state_t           state_q, state_d;
  logic             clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic             data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic             filt_q, filt_d, fe_q, fe_d;
  logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [8:0]       sh_q, sh_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             data_bit_q, data_bit_d;

  // Synchronizers and clock glitch filter; fe is registered so it lasts one cycle.
  always_comb begin
    clk_meta_d  = ps2_clk_in;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data_in;
    data_sync_d = data_meta_q;
    filt_d      = filt_q;
    flt_cnt_d   = '0;
    if (clk_sync_q != filt_q) begin
      if (flt_cnt_q == FLT_LAST) filt_d = clk_sync_q;
      else                       flt_cnt_d = flt_cnt_q + 1'b1;
    end
    fe_d = filt_q & ~filt_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    data_bit_d = data_bit_q;
    unique case (state_q)
      IDLE: begin
        cnt_d      = '0;
        data_bit_d = 1'b0;
        if (tx_start) begin
          sh_d    = {~^tx_data, tx_data};
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          state_d    = SEND;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          data_bit_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == TMO_LAST) begin
          state_d    = ERR;
          data_bit_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (fe_q) begin
            if (bit_cnt_q == 4'd9) begin
              data_bit_d = 1'b0;
              state_d    = ACK;
            end else begin
              data_bit_d = ~sh_q[0];
              sh_d       = {1'b0, sh_q[8:1]};
              bit_cnt_d  = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      ACK: begin
        if (cnt_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (fe_q) state_d = data_sync_q ? ERR : WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (cnt_q == TMO_LAST) begin
          state_d = ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (filt_q && data_sync_q) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_q      <= 1'b1;
      fe_q        <= 1'b0;
      flt_cnt_q   <= '0;
      cnt_q       <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      data_bit_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_q      <= filt_d;
      fe_q        <= fe_d;
      flt_cnt_q   <= flt_cnt_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      data_bit_q  <= data_bit_d;
    end
  end

  // Pin enables decode straight from state so an async reset releases them at once.
  assign tx_ready    = (state_q == IDLE);
  assign tx_done     = (state_q == DONE);
  assign tx_err      = (state_q == ERR);
  assign ps2_clk_oe  = (state_q == INHIBIT);
  assign ps2_data_oe = ((state_q == INHIBIT) && (cnt_q == INH_LAST)) ||
                       ((state_q == SEND) && data_bit_q);

endmodule
